pipe_stage_buf: RTL and testbench



---
 rtl/pipe_stage_buf_pkg.sv | 51 +++++
 rtl/pipe_stage_buf_slot.sv | 35 +++
 rtl/pipe_stage_buf.sv | 113 +++++++++++
 tb/tb_pipe_stage_buf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline package: payload layouts for the inter-stage buffers.
package pipe_stage_buf_pkg;

    // MEM/WB payload: {wreg, m2reg, mo[31:0], alu[31:0], rn[4:0]}
    localparam int RN_W      = 5;
    localparam int WORD_W    = 32;
    localparam int RN_LSB    = 0;
    localparam int ALU_LSB   = RN_LSB + RN_W;
    localparam int MO_LSB    = ALU_LSB + WORD_W;
    localparam int M2REG_BIT = MO_LSB + WORD_W;
    localparam int WREG_BIT  = M2REG_BIT + 1;
    localparam int MWB_W     = WREG_BIT + 1;

    // IF/ID payload: {pc4[31:0], inst[31:0]}
    localparam int IFID_INST_LSB = 0;
    localparam int IFID_PC4_LSB  = IFID_INST_LSB + WORD_W;
    localparam int IFID_W        = IFID_PC4_LSB + WORD_W;

    // ID/EX payload: {wreg, m2reg, wmem, aluc[3:0], aluimm, a, b, imm, rn}
    localparam int IDEX_RN_LSB   = 0;
    localparam int IDEX_IMM_LSB  = IDEX_RN_LSB + RN_W;
    localparam int IDEX_B_LSB    = IDEX_IMM_LSB + WORD_W;
    localparam int IDEX_A_LSB    = IDEX_B_LSB + WORD_W;
    localparam int IDEX_ALUIMM_BIT = IDEX_A_LSB + WORD_W;
    localparam int IDEX_ALUC_LSB = IDEX_ALUIMM_BIT + 1;
    localparam int IDEX_WMEM_BIT = IDEX_ALUC_LSB + 4;
    localparam int IDEX_M2REG_BIT = IDEX_WMEM_BIT + 1;
    localparam int IDEX_WREG_BIT = IDEX_M2REG_BIT + 1;
    localparam int IDEX_W        = IDEX_WREG_BIT + 1;

    // EX/MEM payload: {wreg, m2reg, wmem, alu[31:0], b[31:0], rn[4:0]}
    localparam int EXMEM_RN_LSB   = 0;
    localparam int EXMEM_B_LSB    = EXMEM_RN_LSB + RN_W;
    localparam int EXMEM_ALU_LSB  = EXMEM_B_LSB + WORD_W;
    localparam int EXMEM_WMEM_BIT = EXMEM_ALU_LSB + WORD_W;
    localparam int EXMEM_M2REG_BIT = EXMEM_WMEM_BIT + 1;
    localparam int EXMEM_WREG_BIT = EXMEM_M2REG_BIT + 1;
    localparam int EXMEM_W        = EXMEM_WREG_BIT + 1;

    // Assemble a MEM/WB payload from its fields.
    function automatic logic [MWB_W-1:0] mwb_pack(
        input logic              wreg,
        input logic              m2reg,
        input logic [WORD_W-1:0] mo,
        input logic [WORD_W-1:0] alu,
        input logic [RN_W-1:0]   rn
    );
        return {wreg, m2reg, mo, alu, rn};
    endfunction

endpackage

// File: rtl/pipe_stage_buf_slot.sv
// One buffer slot: a valid bit plus payload register. Flush clears only the
// valid bit; reset clears both. Payload only moves when a real beat arrives.
module pipe_slot
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W = MWB_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Valid/payload register; flush beats load, reset beats everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= src_valid;
            end
            if (!flush && load && src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline register: DEPTH slots in series with valid/ready
// back-pressure, flush, and an optional input skid slot that registers
// in_ready.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int DATA_W      = MWB_W,
    parameter int DEPTH       = 1,
    parameter int SKID        = 0,
    parameter int ZERO_BUBBLE = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+2)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+2);

    logic [DEPTH:0]    r;
    logic [DEPTH-1:0]  v;
    logic [DATA_W-1:0] d [DEPTH];
    logic              sv;
    logic              src0_valid;
    logic [DATA_W-1:0] src0_data;

    // Ready ripples back from the output: a slot can load if it is empty
    // or its successor is loading.
    always_comb begin
        r[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r[i] = !v[i] || r[i+1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        if (i == 0) begin : g_head
            pipe_slot #(.DATA_W(DATA_W)) u_slot (
                .clock     (clock),
                .reset     (reset),
                .flush     (flush),
                .load      (r[0]),
                .src_valid (src0_valid),
                .src_data  (src0_data),
                .valid     (v[0]),
                .data      (d[0])
            );
        end else begin : g_body
            pipe_slot #(.DATA_W(DATA_W)) u_slot (
                .clock     (clock),
                .reset     (reset),
                .flush     (flush),
                .load      (r[i]),
                .src_valid (v[i-1]),
                .src_data  (d[i-1]),
                .valid     (v[i]),
                .data      (d[i])
            );
        end
    end

    if (SKID != 0) begin : g_skid
        logic              skid_load;
        logic [DATA_W-1:0] sd;

        // Full skid drains into slot 0 when it frees; an empty skid catches
        // a beat that slot 0 cannot take this cycle.
        assign skid_load  = sv ? r[0] : (in_valid && !r[0]);

        pipe_slot #(.DATA_W(DATA_W)) u_skid (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush),
            .load      (skid_load),
            .src_valid (!sv),
            .src_data  (in_data),
            .valid     (sv),
            .data      (sd)
        );

        assign in_ready   = !sv;
        assign src0_valid = sv || in_valid;
        assign src0_data  = sv ? sd : in_data;
    end else begin : g_no_skid
        assign sv         = 1'b0;
        assign in_ready   = r[0];
        assign src0_valid = in_valid;
        assign src0_data  = in_data;
    end

    assign out_valid = v[DEPTH-1];

    if (ZERO_BUBBLE != 0) begin : g_zero_bubble
        assign out_data = v[DEPTH-1] ? d[DEPTH-1] : '0;
    end else begin : g_raw_out
        assign out_data = d[DEPTH-1];
    end

    // Count valid slots, skid included.
    always_comb begin
        occupancy = OCC_W'(sv);
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: eight instances covering DEPTH 1..4 x SKID 0/1,
// directed vectors on selected lanes, then a random soak on all lanes with a
// per-lane reference queue.
module tb_pipe_stage_buf;

    localparam int W     = 71;
    localparam int LANES = 8;

    logic clock;
    logic reset;

    logic         iv   [LANES];
    logic [W-1:0] id   [LANES];
    logic         ordy [LANES];
    logic         fl   [LANES];

    logic [LANES-1:0] ov_a;
    logic [LANES-1:0] ir_a;
    logic [W-1:0]     od_a  [LANES];
    logic [2:0]       occ_a [LANES];

    int checks;
    int errors;

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic chk(input string nm, input int lane, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane %0d: got %h want %h", nm, lane, act, exp);
        end
    endtask

    // lane L: DEPTH = L/2 + 1, SKID = L % 2
    for (genvar L = 0; L < LANES; L++) begin : g_lane
        localparam int D  = L / 2 + 1;
        localparam int S  = L % 2;
        localparam int OW = $clog2(D + 2);

        logic [OW-1:0] occ;
        logic [W-1:0]  q [$];
        logic [W-1:0]  exp_d;

        pipe_stage_buf #(.DATA_W(W), .DEPTH(D), .SKID(S), .ZERO_BUBBLE(1)) u_dut (
            .clock     (clock),
            .reset     (reset),
            .in_valid  (iv[L]),
            .in_ready  (ir_a[L]),
            .in_data   (id[L]),
            .flush     (fl[L]),
            .out_valid (ov_a[L]),
            .out_ready (ordy[L]),
            .out_data  (od_a[L]),
            .occupancy (occ)
        );

        assign occ_a[L] = 3'(occ);

        // Scoreboard: pop on output handshake, drop all on flush, push accepted inputs.
        always @(negedge clock) begin
            if (reset) begin
                q.delete();
            end else begin
                chk("occupancy", L, W'(occ), W'(q.size()));
                if (!ov_a[L]) chk("bubble_zero", L, od_a[L], '0);
                if (ov_a[L] && ordy[L]) begin
                    chk("sb_nonempty", L, W'(q.size() != 0), W'(1));
                    if (q.size() != 0) begin
                        exp_d = q.pop_front();
                        chk("out_data", L, od_a[L], exp_d);
                    end
                end
                if (fl[L]) q.delete();
                else if (iv[L] && ir_a[L]) q.push_back(id[L]);
            end
        end

        if (S == 1) begin : g_skid_chk
            logic ir_cap;
            // in_ready must not move when out_ready changes mid-cycle.
            always begin
                @(posedge clock);
                #2 ir_cap = ir_a[L];
                #2;
                if (!reset) begin
                    checks++;
                    assert (ir_a[L] == ir_cap)
                    else begin
                        errors++;
                        $display("FAIL skid_ready_comb lane %0d: got %b want %b", L, ir_a[L], ir_cap);
                    end
                end
            end
        end
    end

    task automatic idle_all();
        for (int l = 0; l < LANES; l++) begin
            iv[l] = 1'b0; id[l] = '0; ordy[l] = 1'b1; fl[l] = 1'b0;
        end
    endtask

    // Drive one cycle on one lane, then check its outputs mid-cycle.
    task automatic vec(input int lane, input bit v, input logic [W-1:0] d, input bit r,
                       input bit f, input bit eov, input logic [W-1:0] eod,
                       input bit eir, input int eocc);
        @(posedge clock);
        #1;
        iv[lane] = v; id[lane] = d; ordy[lane] = r; fl[lane] = f;
        @(negedge clock);
        chk("dir_out_valid", lane, W'(ov_a[lane]), W'(eov));
        chk("dir_out_data", lane, od_a[lane], eod);
        chk("dir_in_ready", lane, W'(ir_a[lane]), W'(eir));
        chk("dir_occupancy", lane, W'(occ_a[lane]), W'(eocc));
    endtask

    initial begin
        logic [95:0] rnd;
        int acc, outd;
        checks = 0;
        errors = 0;

        // reset with garbage on the inputs
        reset = 1'b1;
        for (int l = 0; l < LANES; l++) begin
            iv[l] = 1'b1; id[l] = {W{1'b1}}; ordy[l] = 1'b1; fl[l] = 1'b0;
        end
        @(posedge clock);
        @(negedge clock);
        for (int l = 0; l < LANES; l++) begin
            chk("rst_out_valid", l, W'(ov_a[l]), '0);
            chk("rst_out_data", l, od_a[l], '0);
            chk("rst_occupancy", l, W'(occ_a[l]), '0);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_all();
        @(negedge clock);
        for (int l = 0; l < LANES; l++) begin
            chk("rst_in_ready", l, W'(ir_a[l]), W'(1));
            chk("rst_out_valid2", l, W'(ov_a[l]), '0);
        end

        // streaming: DEPTH=2 SKID=0 (lane 2), beats 1..8 back to back
        for (int t = 0; t < 12; t++) begin
            acc  = (t < 8) ? t : 8;
            outd = (t <= 2) ? 0 : ((t - 2 < 8) ? t - 2 : 8);
            vec(2, t < 8, (t < 8) ? W'(t + 1) : '0, 1'b1, 1'b0,
                (t >= 2 && t < 10), (t >= 2 && t < 10) ? W'(t - 1) : '0, 1'b1, acc - outd);
        end
        idle_all();

        // back-pressure: DEPTH=1 SKID=1 (lane 1)
        vec(1, 1, 'h10, 1, 0, 0, 'h00, 1, 0);
        vec(1, 1, 'h11, 1, 0, 1, 'h10, 1, 1);
        vec(1, 1, 'h12, 0, 0, 1, 'h11, 1, 1);
        vec(1, 0, 'h00, 0, 0, 1, 'h11, 0, 2);
        vec(1, 0, 'h00, 0, 0, 1, 'h11, 0, 2);
        vec(1, 0, 'h00, 1, 0, 1, 'h11, 0, 2);
        vec(1, 0, 'h00, 1, 0, 1, 'h12, 1, 1);
        vec(1, 0, 'h00, 1, 0, 0, 'h00, 1, 0);
        idle_all();

        // flush: DEPTH=3 SKID=0 (lane 4) full with A,B,C; D offered in flush cycle
        vec(4, 1, 'hA, 0, 0, 0, 'h0, 1, 0);
        vec(4, 1, 'hB, 0, 0, 0, 'h0, 1, 1);
        vec(4, 1, 'hC, 0, 0, 0, 'h0, 1, 2);
        vec(4, 1, 'hD, 0, 1, 1, 'hA, 0, 3);
        vec(4, 0, 'h0, 1, 0, 0, 'h0, 1, 0);
        vec(4, 1, 'hE, 1, 0, 0, 'h0, 1, 0);
        vec(4, 0, 'h0, 1, 0, 0, 'h0, 1, 1);
        vec(4, 0, 'h0, 1, 0, 0, 'h0, 1, 1);
        vec(4, 0, 'h0, 1, 0, 1, 'hE, 1, 1);
        vec(4, 0, 'h0, 1, 0, 0, 'h0, 1, 0);
        idle_all();

        // output handshake in the flush cycle: DEPTH=1 SKID=0 (lane 0)
        vec(0, 1, 'h5, 1, 0, 0, 'h0, 1, 0);
        vec(0, 1, 'h6, 1, 1, 1, 'h5, 1, 1);
        vec(0, 0, 'h0, 1, 0, 0, 'h0, 1, 0);
        vec(0, 0, 'h0, 1, 0, 0, 'h0, 1, 0);
        idle_all();

        // random soak on all lanes, one mid-stream reset
        for (int c = 0; c < 2000; c++) begin
            @(posedge clock);
            #1;
            reset = (c == 1000);
            for (int l = 0; l < LANES; l++) begin
                rnd     = {$urandom, $urandom, $urandom};
                iv[l]   = ($urandom_range(99) < 60);
                id[l]   = rnd[W-1:0];
                ordy[l] = ($urandom_range(99) < 70);
                fl[l]   = ($urandom_range(99) < 5);
            end
            #2;
            for (int l = 0; l < LANES; l++) begin
                ordy[l] = ($urandom_range(99) < 70);
            end
        end

        // drain
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_all();
        repeat (10) @(posedge clock);
        @(negedge clock);
        for (int l = 0; l < LANES; l++) begin
            chk("drain_empty", l, W'(occ_a[l]), '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
